uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
Transmit-side sequencer between the downstream FIFO (APB→line) and the o_tx pin.
- Pops one byte from the downstream FIFO when enabled and data is available.
- Frames the byte as start + 8 data bits (LSB first) + optional parity + 1 or 2 stop bits, timed by an internal baud divider.
- Exports busy status to the regmap (tx_status) and a per-frame done pulse for IRQ logic.

Parameters:
DATA_WIDTH, 8, frame data bits; must equal the downstream FIFO data width.
BAUD_DIV_WIDTH, 16, width of the baud divisor.

Ports:
i_apb_pclk  in  1  clock, rising edge.
i_apb_preset  in  1  synchronous reset, active-high.
i_enable  in  1  transmitter enable, from the regmap.
i_baud_div  in  BAUD_DIV_WIDTH  bit period = i_baud_div+1 clocks.
i_parity_en  in  1  append parity bit.
i_parity_odd  in  1  1 = odd parity, 0 = even.
i_stop2  in  1  1 = two stop bits.
i_dfifo_empty  in  1  downstream FIFO empty.
i_dfifo_data  in  DATA_WIDTH  FIFO read data, valid the cycle after o_dfifo_read_req.
o_dfifo_read_req  out  1  one-cycle pop request.
o_tx  out  1  serial line; idle/mark = 1.
o_tx_busy  out  1  high whenever state != IDLE.
o_tx_done  out  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset: state IDLE, o_tx=1, o_dfifo_read_req=0, o_tx_busy=0, o_tx_done=0, baud counter=0, bit counter=0.
- Reset asserted mid-frame takes effect at the next edge: o_tx=1 and the frame is abandoned; the byte already popped is lost.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE → FETCH when i_enable && !i_dfifo_empty at the edge.
- FETCH: exactly 1 cycle; o_dfifo_read_req=1.
- LOAD: exactly 1 cycle.
  - Capture i_dfifo_data into the shift register.
  - Latch i_baud_div, i_parity_en, i_parity_odd, i_stop2.
  - Config changes after LOAD do not affect the current frame.
- Every bit state lasts div+1 cycles, using the latched div; div=0 gives 1 cycle per bit.
- START: o_tx=0.
- DATA: DATA_WIDTH bits, LSB first.
- PARITY: entered only if parity is enabled.
  - Bit = XOR of the data bits (even parity), inverted when i_parity_odd=1.
- STOP: o_tx=1 for 1 or 2 bit periods.
- At the end of STOP:
  - o_tx_done pulses in the next cycle.
  - Go to FETCH if i_enable && !i_dfifo_empty, else IDLE.
  - Inter-frame mark gap for back-to-back bytes is therefore exactly 2 cycles (FETCH and LOAD).
- Latency: if the IDLE check passes at edge k, o_tx falls at edge k+3.
- Frame length: (1 + DATA_WIDTH + P + S)·(div+1) cycles, where P = parity bit (0/1) and S = stop bits (1/2).
- o_tx is 1 in IDLE, FETCH and LOAD.
- i_enable deasserted mid-frame: the current frame completes unchanged; no further pop follows.
- i_dfifo_empty is ignored outside the IDLE and STOP-exit decisions.
- Never pop when empty; at most one o_dfifo_read_req per frame.
- Baud counter: 0..div_latched with wrap; a tick is issued at count==div_latched.
- Bit counter: 0..DATA_WIDTH-1 in DATA, reused as 0..S-1 in STOP.

Decomposition:
- uart_pkg:
  - tx_state_t enum (7 states).
  - UART_DATA_WIDTH = 8.
  - UART_BAUD_DIV_WIDTH = 16.
- Sub-module uart_baud_gen: loadable down/up counter with sync clear, producing a one-cycle bit-end tick.
  - Reused later by the receiver.
- Parity is computed inline in uart_tx_ctrl.

Test Plan:
1. Byte 0x55, div=3, no parity, 1 stop.
   - o_dfifo_read_req is a single pulse; o_tx falls 3 cycles after the IDLE check.
   - Line sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; total 40 cycles; o_tx_done pulse 1 cycle later.
2. Byte 0xA5, div=0, parity on:
   - even parity → parity bit 0;
   - odd parity → parity bit 1.
   - Byte 0x07 with even parity → parity bit 1.
   - Frame 11 cycles; 12 cycles with i_stop2=1.
3. Two bytes queued (0x12, 0x34), div=1.
   - Exactly 2 mark cycles between the last stop bit of 0x12 and the start bit of 0x34.
   - Two read pulses; o_tx_busy stays high throughout.
4. i_enable dropped during DATA bit 3.
   - Frame finishes bit-exact; no second pop although FIFO is non-empty; o_tx_busy falls after STOP.
   - Also change i_baud_div mid-frame → current frame timing unchanged.
5. i_apb_preset asserted during the PARITY state.
   - Next cycle: o_tx=1, o_tx_busy=0, o_tx_done=0.
   - After release, the next queued byte is sent from START cleanly.
6. FIFO empty with i_enable=1 for 100 cycles.
   - No o_dfifo_read_req; o_tx=1; o_tx_busy=0.
   - Write one byte: frame starts within 3 cycles of !i_dfifo_empty.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and defaults used by the transmit controller and its baud generator.
package uart_pkg;

    localparam int UART_DATA_WIDTH     = 8;
    localparam int UART_BAUD_DIV_WIDTH = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_FETCH,
        TX_LOAD,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // States in which a serial bit is on the line and the baud counter runs.
    function automatic logic is_bit_state(input tx_state_t s);
        return (s == TX_START) || (s == TX_DATA) || (s == TX_PARITY) || (s == TX_STOP);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..i_div while running and flags the last cycle of each bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = UART_BAUD_DIV_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || (cnt_q == i_div)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign o_tick = !i_clear && (cnt_q == i_div);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops a byte from the downstream FIFO and serialises it onto o_tx.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int BAUD_DIV_WIDTH = UART_BAUD_DIV_WIDTH
) (
    input  logic                      i_apb_pclk,
    input  logic                      i_apb_preset,
    input  logic                      i_enable,
    input  logic [BAUD_DIV_WIDTH-1:0] i_baud_div,
    input  logic                      i_parity_en,
    input  logic                      i_parity_odd,
    input  logic                      i_stop2,
    input  logic                      i_dfifo_empty,
    input  logic [DATA_WIDTH-1:0]     i_dfifo_data,
    output logic                      o_dfifo_read_req,
    output logic                      o_tx,
    output logic                      o_tx_busy,
    output logic                      o_tx_done
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    tx_state_t                 state_q,    state_d;
    logic [DATA_WIDTH-1:0]     shift_q,    shift_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [BAUD_DIV_WIDTH-1:0] div_q,      div_d;
    logic                      par_en_q,   par_en_d;
    logic                      par_bit_q,  par_bit_d;
    logic                      stop2_q,    stop2_d;
    logic                      tx_q,       tx_d;
    logic                      req_q,      req_d;
    logic                      busy_q,     busy_d;
    logic                      end_q,      end_d;
    logic                      done_q,     done_d;
    logic                      baud_tick;
    logic                      more_data;

    uart_baud_gen #(
        .DIV_WIDTH (BAUD_DIV_WIDTH)
    ) u_baud_gen (
        .i_clk   (i_apb_pclk),
        .i_rst   (i_apb_preset),
        .i_clear (!is_bit_state(state_q)),
        .i_div   (div_q),
        .o_tick  (baud_tick)
    );

    assign more_data = i_enable && !i_dfifo_empty;

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        end_d     = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (more_data) state_d = TX_FETCH;
            end
            TX_FETCH: begin
                state_d = TX_LOAD;
            end
            TX_LOAD: begin
                // Snapshot byte and line config; later register writes wait for the next frame.
                state_d   = TX_START;
                shift_d   = i_dfifo_data;
                div_d     = i_baud_div;
                par_en_d  = i_parity_en;
                par_bit_d = (^i_dfifo_data) ^ i_parity_odd;
                stop2_d   = i_stop2;
                bit_cnt_d = '0;
            end
            TX_START: begin
                if (baud_tick) state_d = TX_DATA;
            end
            TX_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? TX_PARITY : TX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (baud_tick) state_d = TX_STOP;
            end
            TX_STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == BIT_CNT_W'(stop2_q)) begin
                        bit_cnt_d = '0;
                        end_d     = 1'b1;
                        state_d   = more_data ? TX_FETCH : TX_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        // The line register follows the current state, so o_tx trails the FSM by one cycle.
        case (state_q)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = shift_q[0];
            TX_PARITY: tx_d = par_bit_q;
            default:   tx_d = 1'b1;
        endcase

        req_d  = (state_d == TX_FETCH);
        busy_d = (state_d != TX_IDLE);
        done_d = end_q;
    end

    always_ff @(posedge i_apb_pclk) begin
        if (i_apb_preset) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            end_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            end_q     <= end_d;
            done_q    <= done_d;
        end
    end

    assign o_tx             = tx_q;
    assign o_dfifo_read_req = req_q;
    assign o_tx_busy        = busy_q;
    assign o_tx_done        = done_q;

endmodule
